if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage, directly downstream of the pre-IF stage and upstream of ID.
- Accepts the fetch PC when the ICache address handshake fires, then waits for the matching data response.
- Buffers the returned instruction until ID accepts it, and discards responses belonging to flushed fetches.
- Drives fs_pc (pre-IF computes the sequential PC from it) and fs_allowin (gates pre-IF request issue).

Parameters:
- RESET_PC, 32'hbfbffffc, fs_pc value after reset; pre-IF's fs_pc+4 yields boot vector 32'hbfc00000.
- FS_TO_DS_BUS_WD, 70, width of the IF-to-ID bus.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ps_to_fs_bus  in  32  fetch PC (nextpc) from pre-IF
- inst_valid  in  1  pre-IF request valid
- inst_addr_ok  in  1  ICache accepted address
- inst_data_ok  in  1  ICache data return, in order
- inst_rdata  in  32  returned instruction word
- ds_allowin  in  1  ID can accept
- flush  in  1  exception/eret flush from commit
- fs_allowin  out  1  IF can accept a new fetch
- fs_pc  out  32  PC of the instruction currently in IF
- fs_to_ds_valid  out  1  bus valid to ID
- fs_to_ds_bus  out  70  {fs_ex[69], fs_excode[68:64], fs_pc[63:32], fs_inst[31:0]}

Behaviour:
- Definitions:
  - req_fire = inst_valid & inst_addr_ok & fs_allowin.
  - fs_allowin = (state==IDLE) | (fs_ready_go & ds_allowin) | flush.
  - fs_ready_go = (state==HOLD) | (state==WAIT & inst_data_ok & ~cancel).
- FSM states: IDLE (no instruction), WAIT (request outstanding), HOLD (instruction buffered).
  - IDLE: req_fire -> WAIT.
  - WAIT, data_ok with ~cancel: ds_allowin -> (req_fire ? WAIT : IDLE); otherwise latch inst_rdata into inst_buf and go to HOLD.
  - WAIT, data_ok with cancel: clear cancel and stay in WAIT (the cancelled response is consumed).
  - HOLD: ds_allowin -> (req_fire ? WAIT : IDLE).
- On req_fire, fs_pc <= ps_to_fs_bus.
- Output data: fs_to_ds_valid = fs_ready_go & ~flush. fs_inst = (state==WAIT) ? inst_rdata : inst_buf. Zero-latency bypass: data arriving while ID allows in is handed over in the same cycle.
- Flush:
  - Flush forces next state to IDLE, or WAIT if req_fire occurs in the same cycle (the pre-IF redirect fetch).
  - If flush occurs in WAIT without same-cycle data_ok, set cancel=1.
  - If cancel is already set, it stays set.
  - At most one stale response can be outstanding; responses return in order, so the stale one arrives first.
- Simultaneous cases:
  - flush with a handoff: handoff suppressed (valid=0).
  - data_ok in the same cycle as flush: response discarded and cancel not set.
  - cancel=1 in IDLE: only reachable after a flush with no new request. The next data_ok clears cancel; no state change.
- inst_data_ok in IDLE with cancel=0 is a protocol error and is ignored.
- Reset: state=IDLE, cancel=0, fs_pc=RESET_PC, inst_buf=0, fs_ex=0, fs_excode=0. fs_to_ds_valid=0, fs_allowin=1.
- Without the optional feature, fs_ex=0 and fs_excode=0 always.

Optional Feature:
- Macro FS_ADEL_CHECK_EN.
- When defined:
  - On any accepted PC with ps_to_fs_bus[1:0]!=0 (pre-IF raises no ICache request, so the handshake is inst_addr_ok & fs_allowin), latch fs_ex=1 and fs_excode=5'h04 (AdEL) and go to HOLD directly with fs_inst=0.
  - No ICache response is expected for that PC.
- When undefined: misaligned PCs are never accepted (pre-IF holds inst_valid=0); fs_ex/fs_excode are tied to 0.

Decomposition:
- Shared package/global defines: FS_TO_DS_BUS_WD, PS_TO_FS_BUS_WD, RESET_PC constant, EXC_ADEL=5'h04, FSM state encodings.
- No sub-module required; the FSM and cancel bit fit in one module.

Test Plan:
- Reset -> fs_pc=32'hbfbffffc, fs_allowin=1, fs_to_ds_valid=0.
- Fire PC 32'hbfc00000; data_ok next cycle with rdata 32'h24080001, ds_allowin=1 -> same-cycle fs_to_ds_valid=1 with bus pc=bfc00000, inst=24080001; state back to WAIT/IDLE.
- Data returns with ds_allowin=0 for 3 cycles -> state HOLD, fs_allowin=0, bus stable with inst 24080001; ds_allowin=1 -> handoff, then accept next PC.
- Request for bfc00010 outstanding, flush with same-cycle fire of bfc00380 -> first data_ok (stale) dropped, fs_to_ds_valid=0; second data_ok delivers pc=bfc00380.
- Flush in the same cycle as data_ok -> no handoff, cancel stays 0, next data_ok delivered normally.
- FS_ADEL_CHECK_EN defined, PC 32'hbfc00002 accepted -> next cycle fs_to_ds_valid=1, fs_ex=1, fs_excode=04, inst=0, no data_ok awaited.

Source files
------------

// File: rtl/if_stage_pkg.sv
// ============================================================================
// Module      : if_stage_pkg
// Description : Shared constants and types for the instruction-fetch stage:
//               bus widths, reset PC, AdEL exception code and FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_stage_pkg;

  localparam int          FS_TO_DS_BUS_WD = 70;
  localparam int          PS_TO_FS_BUS_WD = 32;
  localparam logic [31:0] RESET_PC        = 32'hbfbffffc;
  localparam logic [4:0]  EXC_ADEL        = 5'h04;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,  // no instruction in IF
    FS_WAIT = 2'd1,  // ICache request outstanding
    FS_HOLD = 2'd2   // instruction buffered, waiting for ID
  } fs_state_e;

endpackage : if_stage_pkg

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage. Accepts the fetch PC on the ICache
//               address handshake, waits for the in-order data response,
//               hands it to ID (zero-latency bypass) or buffers it, and drops
//               responses that belong to flushed fetches.
// Options     : FS_ADEL_CHECK_EN - when defined, a misaligned fetch PC is
//               accepted without an ICache request and delivered to ID with
//               fs_ex=1 / fs_excode=AdEL and a zero instruction word.
// Ports       : clk, reset         - clock, synchronous active-high reset
//               ps_to_fs_bus [32]  - fetch PC from pre-IF
//               inst_valid         - pre-IF request valid
//               inst_addr_ok       - ICache accepted the address
//               inst_data_ok       - ICache data return (in order)
//               inst_rdata [32]    - returned instruction word
//               ds_allowin         - ID can accept
//               flush              - exception/eret flush from commit
//               fs_allowin         - IF can accept a new fetch
//               fs_pc [32]         - PC of the instruction in IF
//               fs_to_ds_valid     - bus valid to ID
//               fs_to_ds_bus [70]  - {fs_ex, fs_excode, fs_pc, fs_inst}
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC_P      = RESET_PC,
  parameter int          FS_TO_DS_BUS_W  = FS_TO_DS_BUS_WD
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PS_TO_FS_BUS_WD-1:0] ps_to_fs_bus,
  input  logic                       inst_valid,
  input  logic                       inst_addr_ok,
  input  logic                       inst_data_ok,
  input  logic [31:0]                inst_rdata,
  input  logic                       ds_allowin,
  input  logic                       flush,
  output logic                       fs_allowin,
  output logic [31:0]                fs_pc,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_W-1:0]  fs_to_ds_bus
);

  fs_state_e   state_q, state_d;
  logic        cancel_q, cancel_d;
  logic [31:0] fs_pc_q, fs_pc_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        fs_ex_q, fs_ex_d;
  logic [4:0]  fs_excode_q, fs_excode_d;

  logic        fs_ready_go;
  logic        req_fire;
  logic        adel_fire;
  logic        any_fire;
  fs_state_e   fire_state;
  logic [31:0] fs_inst;

  // A live response is one that arrives in WAIT and is not a stale leftover.
  assign fs_ready_go = (state_q == FS_HOLD) |
                       ((state_q == FS_WAIT) & inst_data_ok & ~cancel_q);
  assign fs_allowin  = (state_q == FS_IDLE) | (fs_ready_go & ds_allowin) | flush;

`ifdef FS_ADEL_CHECK_EN
  logic misaligned;
  assign misaligned = |ps_to_fs_bus[1:0];
  // Pre-IF raises no ICache request for a misaligned PC, so inst_valid is
  // not part of that handshake.
  assign adel_fire  = inst_addr_ok & fs_allowin & misaligned;
  assign req_fire   = inst_valid & inst_addr_ok & fs_allowin & ~misaligned;
`else
  assign adel_fire  = 1'b0;
  assign req_fire   = inst_valid & inst_addr_ok & fs_allowin;
`endif

  assign any_fire   = req_fire | adel_fire;
  // An AdEL fetch has its "instruction" immediately, so it skips WAIT.
  assign fire_state = adel_fire ? FS_HOLD : FS_WAIT;

  always_comb begin
    state_d     = state_q;
    cancel_d    = cancel_q;
    fs_pc_d     = fs_pc_q;
    inst_buf_d  = inst_buf_q;
    fs_ex_d     = fs_ex_q;
    fs_excode_d = fs_excode_q;

    case (state_q)
      FS_IDLE: begin
        if (any_fire) state_d = fire_state;
      end
      FS_WAIT: begin
        if (inst_data_ok) begin
          if (cancel_q) begin
            // Stale response consumed; keep waiting for ours.
            state_d = FS_WAIT;
          end else if (ds_allowin) begin
            state_d = any_fire ? fire_state : FS_IDLE;
          end else begin
            inst_buf_d = inst_rdata;
            state_d    = FS_HOLD;
          end
        end
      end
      FS_HOLD: begin
        if (ds_allowin) state_d = any_fire ? fire_state : FS_IDLE;
      end
      default: state_d = FS_IDLE;
    endcase

    // Any response seen while cancel is set is the stale one.
    if (cancel_q && inst_data_ok) cancel_d = 1'b0;

    if (flush) begin
      state_d = any_fire ? fire_state : FS_IDLE;
      // The in-flight request will still return; remember to drop it.
      if ((state_q == FS_WAIT) && !inst_data_ok) cancel_d = 1'b1;
    end

    if (any_fire) begin
      fs_pc_d     = ps_to_fs_bus;
      fs_ex_d     = adel_fire;
      fs_excode_d = adel_fire ? EXC_ADEL : 5'h00;
      if (adel_fire) inst_buf_d = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FS_IDLE;
      cancel_q    <= 1'b0;
      fs_pc_q     <= RESET_PC_P;
      inst_buf_q  <= 32'h0;
      fs_ex_q     <= 1'b0;
      fs_excode_q <= 5'h00;
    end else begin
      state_q     <= state_d;
      cancel_q    <= cancel_d;
      fs_pc_q     <= fs_pc_d;
      inst_buf_q  <= inst_buf_d;
      fs_ex_q     <= fs_ex_d;
      fs_excode_q <= fs_excode_d;
    end
  end

  // In WAIT the word comes straight from the ICache (zero-latency bypass).
  assign fs_inst        = (state_q == FS_WAIT) ? inst_rdata : inst_buf_q;
  assign fs_pc          = fs_pc_q;
  assign fs_to_ds_valid = fs_ready_go & ~flush;
  assign fs_to_ds_bus   = {fs_ex_q, fs_excode_q, fs_pc_q, fs_inst};

endmodule : if_stage

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module      : tb_if_stage
// Description : Directed self-checking bench for if_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ps_to_fs_bus;
  logic        inst_valid;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        ds_allowin;
  logic        flush;
  logic        fs_allowin;
  logic [31:0] fs_pc;
  logic        fs_to_ds_valid;
  logic [69:0] fs_to_ds_bus;

  int checks = 0;
  int errors = 0;

  if_stage dut (
    .clk           (clk),
    .reset         (reset),
    .ps_to_fs_bus  (ps_to_fs_bus),
    .inst_valid    (inst_valid),
    .inst_addr_ok  (inst_addr_ok),
    .inst_data_ok  (inst_data_ok),
    .inst_rdata    (inst_rdata),
    .ds_allowin    (ds_allowin),
    .flush         (flush),
    .fs_allowin    (fs_allowin),
    .fs_pc         (fs_pc),
    .fs_to_ds_valid(fs_to_ds_valid),
    .fs_to_ds_bus  (fs_to_ds_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic aok, input logic [31:0] pc,
                       input logic dok, input logic [31:0] rd,
                       input logic dsa, input logic fl);
    inst_valid   = v;
    inst_addr_ok = aok;
    ps_to_fs_bus = pc;
    inst_data_ok = dok;
    inst_rdata   = rd;
    ds_allowin   = dsa;
    flush        = fl;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 32'h0, 0, 32'h0, 1, 0);
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Reset state
    check("rst_pc",      70'(fs_pc), 70'(32'hbfbffffc));
    check("rst_allowin", 70'(fs_allowin), 70'(1'b1));
    check("rst_valid",   70'(fs_to_ds_valid), 70'(1'b0));
    check("rst_bus",     fs_to_ds_bus, {1'b0, 5'h00, 32'hbfbffffc, 32'h0});

    // Fire bfc00000, data next cycle with ID ready: same-cycle handoff
    drive(1, 1, 32'hbfc00000, 0, 32'h0, 1, 0);
    tick();
    check("fire0_pc", 70'(fs_pc), 70'(32'hbfc00000));
    check("fire0_wait_allowin", 70'(fs_allowin), 70'(1'b0));
    drive(0, 0, 32'h0, 1, 32'h24080001, 1, 0);
    check("bypass_valid", 70'(fs_to_ds_valid), 70'(1'b1));
    check("bypass_bus", fs_to_ds_bus, {1'b0, 5'h00, 32'hbfc00000, 32'h24080001});
    check("bypass_allowin", 70'(fs_allowin), 70'(1'b1));
    tick();

    // Back in IDLE; stray data_ok is ignored
    drive(0, 0, 32'h0, 1, 32'h55555555, 1, 0);
    check("idle_stray_valid", 70'(fs_to_ds_valid), 70'(1'b0));
    check("idle_allowin", 70'(fs_allowin), 70'(1'b1));
    tick();

    // Fire bfc00004, data returns while ID stalls -> HOLD
    drive(1, 1, 32'hbfc00004, 0, 32'h0, 0, 0);
    tick();
    drive(0, 0, 32'h0, 1, 32'h24080001, 0, 0);
    check("stall_arrive_valid", 70'(fs_to_ds_valid), 70'(1'b1));
    check("stall_arrive_allowin", 70'(fs_allowin), 70'(1'b0));
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 32'hbfc00010, 0, 32'hdeadbeef, 0, 0);
      check("hold_valid", 70'(fs_to_ds_valid), 70'(1'b1));
      check("hold_allowin", 70'(fs_allowin), 70'(1'b0));
      check("hold_bus", fs_to_ds_bus, {1'b0, 5'h00, 32'hbfc00004, 32'h24080001});
      tick();
    end
    check("hold_no_fire_pc", 70'(fs_pc), 70'(32'hbfc00004));

    // ID accepts; next PC fires in the same cycle
    drive(1, 1, 32'hbfc00010, 0, 32'hdeadbeef, 1, 0);
    check("release_allowin", 70'(fs_allowin), 70'(1'b1));
    check("release_valid", 70'(fs_to_ds_valid), 70'(1'b1));
    tick();
    check("next_pc", 70'(fs_pc), 70'(32'hbfc00010));

    // Flush with bfc00010 outstanding, redirect fetch of bfc00380 same cycle
    drive(1, 1, 32'hbfc00380, 0, 32'h0, 1, 1);
    check("flush_allowin", 70'(fs_allowin), 70'(1'b1));
    check("flush_valid", 70'(fs_to_ds_valid), 70'(1'b0));
    tick();
    check("redirect_pc", 70'(fs_pc), 70'(32'hbfc00380));
    drive(0, 0, 32'h0, 1, 32'h11111111, 1, 0);
    check("stale_valid", 70'(fs_to_ds_valid), 70'(1'b0));
    check("stale_allowin", 70'(fs_allowin), 70'(1'b0));
    tick();
    drive(0, 0, 32'h0, 1, 32'h3c1dbfc0, 1, 0);
    check("redirect_valid", 70'(fs_to_ds_valid), 70'(1'b1));
    check("redirect_bus", fs_to_ds_bus, {1'b0, 5'h00, 32'hbfc00380, 32'h3c1dbfc0});
    tick();

    // Flush in the same cycle as data_ok: dropped, cancel not set
    drive(1, 1, 32'hbfc00384, 0, 32'h0, 1, 0);
    tick();
    drive(0, 0, 32'h0, 1, 32'h22222222, 1, 1);
    check("flushdata_valid", 70'(fs_to_ds_valid), 70'(1'b0));
    check("flushdata_allowin", 70'(fs_allowin), 70'(1'b1));
    tick();
    drive(0, 0, 32'h0, 0, 32'h0, 1, 0);
    check("after_flush_idle_allowin", 70'(fs_allowin), 70'(1'b1));
    drive(1, 1, 32'hbfc00388, 0, 32'h0, 1, 0);
    tick();
    drive(0, 0, 32'h0, 1, 32'h33333333, 1, 0);
    check("nocancel_valid", 70'(fs_to_ds_valid), 70'(1'b1));
    check("nocancel_bus", fs_to_ds_bus, {1'b0, 5'h00, 32'hbfc00388, 32'h33333333});
    tick();

    // Flush while HOLD drops the buffered instruction
    drive(1, 1, 32'hbfc0038c, 0, 32'h0, 0, 0);
    tick();
    drive(0, 0, 32'h0, 1, 32'h44444444, 0, 0);
    tick();
    drive(0, 0, 32'h0, 0, 32'h0, 0, 1);
    check("holdflush_valid", 70'(fs_to_ds_valid), 70'(1'b0));
    tick();
    drive(0, 0, 32'h0, 0, 32'h0, 0, 0);
    check("holdflush_idle_allowin", 70'(fs_allowin), 70'(1'b1));
    check("holdflush_idle_valid", 70'(fs_to_ds_valid), 70'(1'b0));

`ifdef FS_ADEL_CHECK_EN
    // Misaligned PC: AdEL delivered next cycle, no ICache response awaited
    drive(0, 1, 32'hbfc00002, 0, 32'h0, 1, 0);
    tick();
    drive(0, 0, 32'h0, 0, 32'h77777777, 1, 0);
    check("adel_valid", 70'(fs_to_ds_valid), 70'(1'b1));
    check("adel_bus", fs_to_ds_bus, {1'b1, 5'h04, 32'hbfc00002, 32'h0});
    tick();
    check("adel_done_valid", 70'(fs_to_ds_valid), 70'(1'b0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_if_stage

`default_nettype wire
